pwm_ramp_ctrl: RTL

Duty-cycle sequencer for the single-channel `pwm` block. It accepts a target duty, a step size and a rate divider over a valid/ready handshake. It then ramps its `duty` output toward the target, changing it only at PWM period boundaries so the downstream comparator never sees a mid-period duty change. `duty` drives the `pwm` `in` port directly; both blocks share `clk` and `rst` so their free-running counters stay phase-aligned.

---
 rtl/pwm_ramp_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer for the single-channel pwm block.
// Accepts target/step/divider commands and moves duty toward the target only at PWM period boundaries.
module pwm_ramp_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIVW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tgt_valid,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] tgt_duty,
   input  logic [WIDTH-1:0] tgt_step,
   input  logic [DIVW-1:0]  tgt_div,
   input  logic             hold,
   output logic [WIDTH-1:0] duty,
   output logic             period_end,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RAMP} state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] phase_q,  phase_d;
   logic [WIDTH-1:0] duty_q,   duty_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] step_q,   step_d;
   logic [DIVW-1:0]  div_q,    div_d;
   logic [DIVW-1:0]  divcnt_q, divcnt_d;
   logic             done_q,   done_d;

   logic             accept;
   logic [WIDTH:0]   up_sum;
   logic [WIDTH:0]   down_diff;
   logic [WIDTH-1:0] next_duty;

   assign accept     = tgt_valid && (state_q == IDLE);
   assign period_end = &phase_q;
   assign tgt_ready  = (state_q == IDLE);
   assign busy       = (state_q == RAMP);
   assign duty       = duty_q;
   assign done       = done_q;

   // One extra bit so duty+step and duty-step can be clamped instead of wrapping.
   always_comb begin
      up_sum    = {1'b0, duty_q} + {1'b0, step_q};
      down_diff = {1'b0, duty_q} - {1'b0, step_q};
      next_duty = target_q;
      if (step_q != '0) begin
         if (duty_q < target_q) begin
            if (up_sum < {1'b0, target_q}) next_duty = up_sum[WIDTH-1:0];
         end else begin
            if (!down_diff[WIDTH] && (down_diff > {1'b0, target_q})) next_duty = down_diff[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      // NOTE: every _d starts at its current value so no path through the case leaves a latch.
      state_d  = state_q;
      phase_d  = phase_q + 1'b1;
      duty_d   = duty_q;
      target_d = target_q;
      step_d   = step_q;
      div_d    = div_q;
      divcnt_d = divcnt_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               target_d = tgt_duty;
               step_d   = tgt_step;
               div_d    = tgt_div;
               divcnt_d = '0;
               if (tgt_duty == duty_q) done_d  = 1'b1;
               else                    state_d = RAMP;
            end
         end
         RAMP: begin
            // hold freezes duty, divider and state; the phase counter keeps running.
            if (period_end && !hold) begin
               if (divcnt_q == div_q) begin
                  duty_d   = next_duty;
                  divcnt_d = '0;
                  if (next_duty == target_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  divcnt_d = divcnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         duty_q   <= '0;
         target_q <= '0;
         step_q   <= '0;
         div_q    <= '0;
         divcnt_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         duty_q   <= duty_d;
         target_q <= target_d;
         step_q   <= step_d;
         div_q    <= div_d;
         divcnt_q <= divcnt_d;
         done_q   <= done_d;
      end
   end

endmodule
